// File: rtl/elevator_controller.sv
// Elevator controller: synchronized 1 Hz tick, latched floor calls, IDLE/MOVE/DOOR FSM.
// Define ELEVATOR_ESTOP_EN to add the estop input (freezes motion and timing while high).
module elevator_controller #(
  parameter int NUM_FLOORS = 4,
  parameter int FLOOR_TIME = 3,
  parameter int DOOR_TIME  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick_1s,
  input  logic [NUM_FLOORS-1:0] call_req,
`ifdef ELEVATOR_ESTOP_EN
  input  logic                  estop,
`endif
  output logic [2:0]            floor_o,
  output logic                  moving_up,
  output logic                  moving_down,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending
);

  typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN, S_DOOR} state_t;

  localparam logic [3:0] FT_LAST = 4'(FLOOR_TIME - 1);
  localparam logic [3:0] DT_LAST = 4'(DOOR_TIME - 1);
  localparam logic [3:0] T_MAX   = 4'hF;

  logic                  sync1_q, sync2_q, sync3_q, sec_pulse_q;
  state_t                state_q, state_d;
  logic [2:0]            floor_q, floor_d, floor_up, floor_dn, floor_out_q;
  logic [3:0]            timer_q, timer_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d, pend_eff, pend_out_q;
  logic                  last_dir_q, last_dir_d;
  logic                  up_q, up_d, down_q, down_d, door_q, door_d;
  logic                  reenter, entry, step;

  function automatic logic bit_at(input logic [NUM_FLOORS-1:0] m, input logic [2:0] f);
    bit_at = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++)
      if (i == int'(f)) bit_at = m[i];
  endfunction

  function automatic logic any_above(input logic [NUM_FLOORS-1:0] m, input logic [2:0] f);
    any_above = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++)
      if (i > int'(f) && m[i]) any_above = 1'b1;
  endfunction

  function automatic logic any_below(input logic [NUM_FLOORS-1:0] m, input logic [2:0] f);
    any_below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++)
      if (i < int'(f) && m[i]) any_below = 1'b1;
  endfunction

  // State register plus registered outputs (outputs trail the state by one cycle)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync3_q     <= 1'b0;
      sec_pulse_q <= 1'b0;
      state_q     <= S_IDLE;
      floor_q     <= 3'd0;
      timer_q     <= 4'd0;
      pending_q   <= '0;
      last_dir_q  <= 1'b1;
      up_q        <= 1'b0;
      down_q      <= 1'b0;
      door_q      <= 1'b0;
      floor_out_q <= 3'd0;
      pend_out_q  <= '0;
    end else begin
      sync1_q     <= tick_1s;
      sync2_q     <= sync1_q;
      sync3_q     <= sync2_q;
      sec_pulse_q <= sync2_q & ~sync3_q;
      state_q     <= state_d;
      floor_q     <= floor_d;
      timer_q     <= timer_d;
      pending_q   <= pending_d;
      last_dir_q  <= last_dir_d;
      up_q        <= up_d;
      down_q      <= down_d;
      door_q      <= door_d;
      floor_out_q <= floor_q;
      pend_out_q  <= pending_q;
    end
  end

  // Next-state: decisions look at calls arriving this cycle too, so a
  // button pressed exactly on arrival still opens the door there.
  always_comb begin
    state_d  = state_q;
    floor_d  = floor_q;
    reenter  = 1'b0;
    pend_eff = pending_q | call_req;
    floor_up = floor_q + 3'd1;
    floor_dn = floor_q - 3'd1;
    step     = sec_pulse_q && (timer_q == FT_LAST);
    case (state_q)
      S_IDLE: begin
        if (bit_at(pend_eff, floor_q))
          state_d = S_DOOR;
        else if (any_above(pend_eff, floor_q) && any_below(pend_eff, floor_q))
          state_d = last_dir_q ? S_UP : S_DOWN;
        else if (any_above(pend_eff, floor_q))
          state_d = S_UP;
        else if (any_below(pend_eff, floor_q))
          state_d = S_DOWN;
      end
      S_UP: if (step) begin
        floor_d = floor_up;
        if (bit_at(pend_eff, floor_up))         state_d = S_DOOR;
        else if (any_above(pend_eff, floor_up)) reenter = 1'b1;
        else                                    state_d = S_IDLE;
      end
      S_DOWN: if (step) begin
        floor_d = floor_dn;
        if (bit_at(pend_eff, floor_dn))         state_d = S_DOOR;
        else if (any_below(pend_eff, floor_dn)) reenter = 1'b1;
        else                                    state_d = S_IDLE;
      end
      S_DOOR: if (sec_pulse_q && (timer_q == DT_LAST)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifdef ELEVATOR_ESTOP_EN
    if (estop) begin
      state_d = state_q;
      floor_d = floor_q;
      reenter = 1'b0;
    end
`endif
    entry   = (state_d != state_q) || reenter;
    timer_d = timer_q;
    if (entry)
      timer_d = 4'd0;
    else if (sec_pulse_q && (timer_q != T_MAX))
      timer_d = timer_q + 4'd1;
`ifdef ELEVATOR_ESTOP_EN
    if (estop) timer_d = timer_q;
`endif
    last_dir_d = last_dir_q;
    if (entry && state_d == S_UP)   last_dir_d = 1'b1;
    if (entry && state_d == S_DOWN) last_dir_d = 1'b0;
    pending_d = pend_eff;
    for (int i = 0; i < NUM_FLOORS; i++)
      if (state_d == S_DOOR && i == int'(floor_d)) pending_d[i] = 1'b0;
  end

  always_comb begin
    up_d   = (state_q == S_UP);
    down_d = (state_q == S_DOWN);
    door_d = (state_q == S_DOOR);
`ifdef ELEVATOR_ESTOP_EN
    if (estop) begin
      up_d   = 1'b0;
      down_d = 1'b0;
      door_d = door_q;
    end
`endif
  end

  assign floor_o     = floor_out_q;
  assign moving_up   = up_q;
  assign moving_down = down_q;
  assign door_open   = door_q;
  assign pending     = pend_out_q;

endmodule

// File: tb/tb_elevator_controller.sv
// Scoreboard bench for elevator_controller: expected output transitions (tagged with the
// count of 1 s ticks issued so far) are queued by the stimulus and popped by a monitor.
module tb_elevator_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1s = 1'b0;
  logic [3:0] call_req = 4'd0;
  logic [2:0] floor_o;
  logic       moving_up, moving_down, door_open;
  logic [3:0] pending;
`ifdef ELEVATOR_ESTOP_EN
  logic       estop = 1'b0;
`endif

  elevator_controller dut (
    .clk(clk), .rst(rst), .tick_1s(tick_1s), .call_req(call_req),
`ifdef ELEVATOR_ESTOP_EN
    .estop(estop),
`endif
    .floor_o(floor_o), .moving_up(moving_up), .moving_down(moving_down),
    .door_open(door_open), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         tick;
    logic [2:0] fl;
    logic       up, dn, dr;
    logic [3:0] pd;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  failures = 0;
  int  tick_cnt = 0;
  int  sp_cnt = 0;
  int  ev_idx = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic exp_ev(input int t, input int fl, input bit up, input bit dn, input bit dr,
                        input logic [3:0] pd);
    ev_t e;
    e.tick = t; e.fl = 3'(fl); e.up = up; e.dn = dn; e.dr = dr; e.pd = pd;
    q.push_back(e);
  endtask

  // Monitor: every change of floor/motor/door is one DUT output event
  logic [5:0] prev = 6'd0;
  always @(negedge clk) begin
    logic [5:0] cur;
    ev_t e;
    cur = {floor_o, moving_up, moving_down, door_open};
    if (cur != prev) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL event%0d unexpected: floor=%0d up=%b dn=%b door=%b pend=%b tick=%0d",
                 ev_idx, floor_o, moving_up, moving_down, door_open, pending, tick_cnt);
      end else begin
        e = q.pop_front();
        if (e.tick != tick_cnt || e.fl != floor_o || e.up != moving_up || e.dn != moving_down ||
            e.dr != door_open || e.pd != pending) begin
          failures++;
          $display("FAIL event%0d: got tick=%0d floor=%0d up=%b dn=%b door=%b pend=%b, expected tick=%0d floor=%0d up=%b dn=%b door=%b pend=%b",
                   ev_idx, tick_cnt, floor_o, moving_up, moving_down, door_open, pending,
                   e.tick, e.fl, e.up, e.dn, e.dr, e.pd);
        end
      end
      ev_idx++;
      prev = cur;
    end
  end

  always @(posedge clk) if (dut.sec_pulse_q) sp_cnt++;

  task automatic tick_n(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk); tick_1s = 1'b1; tick_cnt++;
      repeat (8) @(negedge clk);
      tick_1s = 1'b0;
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic pulse_call(input logic [3:0] v);
    @(negedge clk); call_req = v;
    @(negedge clk); call_req = 4'd0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    #3;
    check("reset_floor", floor_o, 0);
    check("reset_motor", {moving_up, moving_down, door_open}, 0);
    check("reset_pending", pending, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single call to floor 2
    exp_ev(0, 0, 1, 0, 0, 4'b0100);
    exp_ev(3, 1, 1, 0, 0, 4'b0100);
    exp_ev(6, 2, 0, 0, 1, 4'b0000);
    exp_ev(11, 2, 0, 0, 0, 4'b0000);
    pulse_call(4'b0100);
    tick_n(11);

    // Calls above and below with last_dir up: serve floor 3 first, then floor 0
    exp_ev(11, 2, 1, 0, 0, 4'b1001);
    exp_ev(14, 3, 0, 0, 1, 4'b0001);
    exp_ev(19, 3, 0, 0, 0, 4'b0001);
    exp_ev(19, 3, 0, 1, 0, 4'b0001);
    exp_ev(22, 2, 0, 1, 0, 4'b0001);
    exp_ev(25, 1, 0, 1, 0, 4'b0001);
    exp_ev(28, 0, 0, 0, 1, 4'b0000);
    exp_ev(33, 0, 0, 0, 0, 4'b0000);
    pulse_call(4'b1001);
    tick_n(22);

    // Call for floor 1 held through the door period is absorbed
    exp_ev(33, 0, 1, 0, 0, 4'b0010);
    exp_ev(36, 1, 0, 0, 1, 4'b0000);
    exp_ev(41, 1, 0, 0, 0, 4'b0000);
    @(negedge clk); call_req = 4'b0010;
    repeat (4) @(negedge clk);
    tick_n(5);
    check("held_call_pending", pending, 0);
    check("held_call_door", door_open, 1);
    call_req = 4'd0;
    tick_n(3);

    // Synchronizer: one pulse per tick, latency of three clocks
    base = sp_cnt;
    @(negedge clk); tick_1s = 1'b1;
    @(negedge clk); tick_1s = 1'b0;
    repeat (10) @(negedge clk);
    check("short_tick_pulses", sp_cnt - base, 1);
    base = sp_cnt;
    @(negedge clk); tick_1s = 1'b1;
    @(negedge clk); check("sec_pulse_edge1", dut.sec_pulse_q, 0);
    @(negedge clk); check("sec_pulse_edge2", dut.sec_pulse_q, 0);
    @(negedge clk); check("sec_pulse_edge3", dut.sec_pulse_q, 1);
    repeat (997) @(negedge clk);
    tick_1s = 1'b0;
    repeat (10) @(negedge clk);
    check("long_tick_pulses", sp_cnt - base, 1);

    // Reset between floors 1 and 2
    exp_ev(41, 1, 1, 0, 0, 4'b0100);
    exp_ev(42, 0, 0, 0, 0, 4'b0000);
    pulse_call(4'b0100);
    tick_n(1);
    @(negedge clk); #2 rst = 1'b1;
    #1;
    check("async_rst_floor", floor_o, 0);
    check("async_rst_outputs", {moving_up, moving_down, door_open}, 0);
    check("async_rst_pending", pending, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick_n(3);
    check("post_rst_floor", floor_o, 0);
    check("post_rst_idle", {moving_up, moving_down, door_open}, 0);

    // Call at the current floor opens the door directly
    exp_ev(45, 0, 0, 0, 1, 4'b0000);
    exp_ev(50, 0, 0, 0, 0, 4'b0000);
    pulse_call(4'b0001);
    tick_n(5);

`ifdef ELEVATOR_ESTOP_EN
    exp_ev(50, 0, 1, 0, 0, 4'b0010);
    exp_ev(52, 0, 0, 0, 0, 4'b0010);
    exp_ev(62, 0, 1, 0, 0, 4'b0010);
    exp_ev(63, 1, 0, 0, 1, 4'b0000);
    exp_ev(68, 1, 0, 0, 0, 4'b0000);
    pulse_call(4'b0010);
    tick_n(2);
    @(negedge clk); estop = 1'b1;
    repeat (4) @(negedge clk);
    tick_n(10);
    check("estop_floor_frozen", floor_o, 0);
    @(negedge clk); estop = 1'b0;
    repeat (4) @(negedge clk);
    tick_n(6);
`endif

    repeat (20) @(negedge clk);
    check("events_outstanding", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
